// File: rtl/pipe_int_mul_resp_pkg.sv
// Shared definitions for the integer multiplier and its response buffer.
// Holds the default product width, the default buffer depth, the derived
// pointer width, and a helper for computing pointer widths from a depth.
package pipe_int_mul_resp_pkg;

  localparam int unsigned MUL_WIDTH = 64;
  localparam int unsigned MUL_DEPTH = 4;
  localparam int unsigned MUL_PTR_W = $clog2(MUL_DEPTH);

  // Index width for a power-of-two buffer of the given depth. The FIFO adds
  // one extra wrap bit on top of this value.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_int_mul_resp_fifo.sv
// Response FIFO for the multiplier: storage, read/write pointers, full/empty.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   wr_en, wr_data  - push request and data (dropped when full without a pop)
//   rd_en           - pop request (ignored when empty)
//   rd_data         - oldest entry (don't-care when empty)
//   full, empty     - occupancy flags
module pipe_int_mul_resp_fifo
  import pipe_int_mul_resp_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned DEPTH = MUL_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = ptr_w(DEPTH);

  // Pointers carry one wrap bit above the index so full and empty can be
  // told apart when the index bits match.
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd, do_wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still lands.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pipe_int_mul_resp.sv
// Response-side flow control for the pipelined integer multiplier.
// Hands out credits to the issuer so that every accepted operand pair is
// guaranteed a buffer slot, buffers committed products in order, and flags
// protocol violations in a sticky overflow bit.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   issue               - multiplier accepted an operand pair (claims a credit)
//   commit, result      - multiplier produced a product this cycle
//   issue_ok            - a credit is free
//   resp_val, resp_rdy  - response handshake
//   resp_data           - oldest buffered product
//   overflow            - sticky: issue without credit or commit into full FIFO
module pipe_int_mul_resp
  import pipe_int_mul_resp_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned DEPTH = MUL_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             commit,
  input  logic [WIDTH-1:0] result,
  output logic             issue_ok,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [WIDTH-1:0] resp_data,
  output logic             overflow
);

  localparam int unsigned    CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(DEPTH);

  logic [CW-1:0] credits_q, credits_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic          dequeue, issue_take;

  pipe_int_mul_resp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (commit),
    .wr_data (result),
    .rd_en   (dequeue),
    .rd_data (resp_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign resp_val   = !fifo_empty;
  assign dequeue    = resp_val && resp_rdy;
  assign issue_ok   = (credits_q != '0);
  assign issue_take = issue && issue_ok;
  assign overflow   = overflow_q;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    credits_d = credits_q;
    unique case ({issue_take, dequeue})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    overflow_d = overflow_q
               | (issue && !issue_ok)
               | (commit && fifo_full && !dequeue);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q  <= CRED_MAX;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pipe_int_mul_resp.sv
// Self-checking bench for pipe_int_mul_resp. Expected products are queued
// when a commit is driven that must be kept, and compared when the DUT
// hands a product out.
module tb_pipe_int_mul_resp;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue;
  logic             commit;
  logic [WIDTH-1:0] result;
  logic             issue_ok;
  logic             resp_val;
  logic             resp_rdy;
  logic [WIDTH-1:0] resp_data;
  logic             overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WIDTH-1:0] sb [$];

  pipe_int_mul_resp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .commit    (commit),
    .result    (result),
    .issue_ok  (issue_ok),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a product leaves the DUT at the posedge following a
  // negedge where resp_val && resp_rdy hold outside reset.
  always @(negedge clk) begin
    if (!reset && resp_val && resp_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %0h, required no product", resp_data);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        if (resp_data !== exp) begin
          errors++;
          $display("FAIL resp_order: got %0h, required %0h", resp_data, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; issue = 1'b0; commit = 1'b0; result = '0; resp_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Issue and commit n products in lockstep with resp_rdy low.
  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    resp_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      issue = 1'b1; commit = 1'b1; result = base + WIDTH'(i);
      sb.push_back(result);
      tick();
    end
    issue = 1'b0; commit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (resp_val !== 1'b0 || issue_ok !== 1'b1 || overflow !== 1'b0 ||
        dut.credits_q !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL reset_state: val=%b ok=%b ovf=%b cred=%0d, required 0 1 0 %0d",
               resp_val, issue_ok, overflow, dut.credits_q, DEPTH);
    end
  endtask

  task automatic test_single();
    do_reset();
    resp_rdy = 1'b1;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    checks++;
    if (dut.credits_q !== 3'd3 || issue_ok !== 1'b1) begin
      errors++;
      $display("FAIL single_credit: cred=%0d ok=%b, required 3 1", dut.credits_q, issue_ok);
    end
    tick(); tick(); tick();
    checks++;
    if (resp_val !== 1'b0) begin
      errors++;
      $display("FAIL single_early: resp_val=%b, required 0", resp_val);
    end
    commit = 1'b1; result = 64'h0000_0000_0000_0006;
    sb.push_back(result);
    tick();
    commit = 1'b0;
    checks++;
    if (resp_val !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: resp_val=%b, required 1", resp_val);
    end
    tick();
    checks++;
    if (dut.credits_q !== 3'(DEPTH) || resp_val !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: cred=%0d val=%b pending=%0d, required %0d 0 0",
               dut.credits_q, resp_val, sb.size(), DEPTH);
    end
  endtask

  task automatic test_order();
    do_reset();
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    checks++;
    if (issue_ok !== 1'b0) begin
      errors++;
      $display("FAIL order_credits_exhausted: issue_ok=%b, required 0", issue_ok);
    end
    for (int i = 1; i <= 4; i++) begin
      commit = 1'b1; result = WIDTH'(i);
      sb.push_back(result);
      tick();
    end
    commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_val !== 1'b1 || resp_data !== 64'd1) begin
        errors++;
        $display("FAIL order_hold: val=%b data=%0h, required 1 1", resp_val, resp_data);
      end
      tick();
    end
    resp_rdy = 1'b1;
    tick();
    checks++;
    if (issue_ok !== 1'b1) begin
      errors++;
      $display("FAIL order_credit_return: issue_ok=%b, required 1", issue_ok);
    end
    tick(); tick(); tick();
    checks++;
    if (resp_val !== 1'b0 || sb.size() != 0 || dut.credits_q !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL order_drain: val=%b pending=%0d cred=%0d, required 0 0 %0d",
               resp_val, sb.size(), dut.credits_q, DEPTH);
    end
  endtask

  task automatic test_issue_overflow();
    do_reset();
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: overflow=%b, required 0", overflow);
    end
    tick();
    issue = 1'b0;
    checks++;
    if (overflow !== 1'b1 || dut.credits_q !== 3'd0) begin
      errors++;
      $display("FAIL ovf_issue: ovf=%b cred=%0d, required 1 0", overflow, dut.credits_q);
    end
    tick(); tick(); tick();
    checks++;
    if (overflow !== 1'b1 || dut.credits_q !== 3'd0) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b cred=%0d, required 1 0", overflow, dut.credits_q);
    end
  endtask

  task automatic test_full_commit_deq();
    do_reset();
    fill(4, 64'd1);
    commit = 1'b1; result = 64'd9; resp_rdy = 1'b1;
    sb.push_back(result);
    tick();
    commit = 1'b0;
    checks++;
    if (overflow !== 1'b0 || resp_val !== 1'b1) begin
      errors++;
      $display("FAIL full_deq_commit: ovf=%b val=%b, required 0 1", overflow, resp_val);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (resp_val !== 1'b0 || sb.size() != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_deq_drain: val=%b pending=%0d ovf=%b, required 0 0 0",
               resp_val, sb.size(), overflow);
    end
  endtask

  task automatic test_full_commit_drop();
    do_reset();
    fill(4, 64'd5);
    commit = 1'b1; result = 64'd9; resp_rdy = 1'b0;
    tick();
    commit = 1'b0;
    checks++;
    if (overflow !== 1'b1 || resp_data !== 64'd5) begin
      errors++;
      $display("FAIL full_drop: ovf=%b data=%0h, required 1 5", overflow, resp_data);
    end
    resp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (resp_val !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_drop_drain: val=%b pending=%0d, required 0 0", resp_val, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(3, 64'h100);
    issue = 1'b1;
    tick(); tick();
    issue = 1'b0;
    checks++;
    if (resp_val !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: val=%b ovf=%b, required 1 1", resp_val, overflow);
    end
    reset = 1'b1; issue = 1'b1; commit = 1'b1; result = 64'hdead; resp_rdy = 1'b1;
    tick();
    reset = 1'b0; issue = 1'b0; commit = 1'b0; resp_rdy = 1'b0;
    sb.delete();
    checks++;
    if (resp_val !== 1'b0 || issue_ok !== 1'b1 || overflow !== 1'b0 ||
        dut.credits_q !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL mid_reset: val=%b ok=%b ovf=%b cred=%0d, required 0 1 0 %0d",
               resp_val, issue_ok, overflow, dut.credits_q, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_issue_overflow();
    test_full_commit_deq();
    test_full_commit_drop();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
